// File: rtl/cache_t0_pkg.sv
// Shared definitions for the way-0 tag lookup / refill controller.
// Holds the address geometry, the controller state encoding and the helpers
// that split a CPU byte address into its tag, index and line-address fields.
package cache_t0_pkg;

  localparam int AWIDTH  = 3;                         // index width
  localparam int TWIDTH  = 13;                        // tag width
  localparam int OWIDTH  = 2;                         // byte-offset width
  localparam int DEPTH   = 32'd1 << AWIDTH;           // tag RAM entries
  localparam int EWIDTH  = TWIDTH + 1;                // {valid, tag}
  localparam int RAWIDTH = TWIDTH + AWIDTH + OWIDTH;  // request address width
  localparam int LWIDTH  = TWIDTH + AWIDTH;           // line address width

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_LOOKUP  = 3'd2,
    ST_MEMREQ  = 3'd3,
    ST_MEMWAIT = 3'd4,
    ST_UPDATE  = 3'd5
  } state_e;

  // Tag field of a byte address.
  function automatic logic [TWIDTH-1:0] get_tag(input logic [RAWIDTH-1:0] addr);
    return addr[RAWIDTH-1:AWIDTH+OWIDTH];
  endfunction

  // Index field of a byte address.
  function automatic logic [AWIDTH-1:0] get_index(input logic [RAWIDTH-1:0] addr);
    return addr[AWIDTH+OWIDTH-1:OWIDTH];
  endfunction

  // Line address presented to memory on a refill.
  function automatic logic [LWIDTH-1:0] line_addr(input logic [TWIDTH-1:0] tag,
                                                  input logic [AWIDTH-1:0] index);
    return {tag, index};
  endfunction

endpackage

// File: rtl/tag_lookup_ctrl_t0.sv
// Lookup and refill controller for cache way 0.
// Sits in front of a synchronous-read tag RAM: drives its address / write data /
// write enable and consumes its registered read data one cycle later.
// After reset (or a flush pulse in IDLE) every entry is overwritten with zero so
// no stale valid bit survives from the file-initialised RAM contents.
// Ports:
//   clock, reset_n               : clock (rising edge), async active-low reset
//   req_valid/req_ready/req_addr : CPU request handshake and byte address
//   flush                        : re-run the invalidate sweep (honoured in IDLE only)
//   resp_valid/resp_hit          : one-cycle response strobe, 1 = hit, 0 = refilled miss
//   tag_addr/tag_din/tag_we      : tag RAM address, write data, write enable
//   tag_dout                     : tag RAM read data, valid the cycle after tag_addr
//   mem_req_valid/ready/addr     : line fetch request handshake, line = {tag, index}
//   mem_rsp_valid                : line data returned by memory
module tag_lookup_ctrl_t0
  import cache_t0_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [RAWIDTH-1:0] req_addr,
  input  logic               flush,
  output logic               resp_valid,
  output logic               resp_hit,
  output logic [AWIDTH-1:0]  tag_addr,
  output logic [EWIDTH-1:0]  tag_din,
  output logic               tag_we,
  input  logic [EWIDTH-1:0]  tag_dout,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [LWIDTH-1:0]  mem_req_addr,
  input  logic               mem_rsp_valid
);

  localparam logic [AWIDTH-1:0] LAST_INDEX = AWIDTH'(DEPTH - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [AWIDTH-1:0] r_init_cnt;
  logic [TWIDTH-1:0] r_tag;
  logic [AWIDTH-1:0] r_index;
  logic              w_hit;
  logic              w_accept;
  logic              w_unused_offset;

  // Byte offset does not take part in tag lookup.
  assign w_unused_offset = ^req_addr[OWIDTH-1:0];

  // RAM read data is valid in LOOKUP because the index was presented in IDLE.
  assign w_hit    = tag_dout[TWIDTH] & (tag_dout[TWIDTH-1:0] == r_tag);
  assign w_accept = (r_state == ST_IDLE) & req_valid & ~flush;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sweep counter: advances through every index in INIT, re-armed by a flush.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_init_cnt <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_cnt <= r_init_cnt + AWIDTH'(1);
    end else if ((r_state == ST_IDLE) && flush) begin
      r_init_cnt <= '0;
    end else begin
      r_init_cnt <= r_init_cnt;
    end
  end

  // Capture the tag and index of an accepted request for the rest of its life.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tag   <= '0;
      r_index <= '0;
    end else if (w_accept) begin
      r_tag   <= get_tag(req_addr);
      r_index <= get_index(req_addr);
    end else begin
      r_tag   <= r_tag;
      r_index <= r_index;
    end
  end

  // Next-state and output decode; outputs depend only on registered state,
  // latched fields, the IDLE request inputs and the RAM read data.
  always_comb begin
    w_state_nxt   = r_state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_hit      = 1'b0;
    tag_addr      = '0;
    tag_din       = '0;
    tag_we        = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    case (r_state)
      ST_INIT: begin
        tag_addr = r_init_cnt;
        tag_we   = 1'b1;
        if (r_init_cnt == LAST_INDEX) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_INIT;
        end
      end
      ST_IDLE: begin
        req_ready = ~flush;
        tag_addr  = get_index(req_addr);
        // Flush wins over a simultaneous request.
        if (flush) begin
          w_state_nxt = ST_INIT;
        end else if (req_valid) begin
          w_state_nxt = ST_LOOKUP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        tag_addr = r_index;
        if (w_hit) begin
          resp_valid  = 1'b1;
          resp_hit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_MEMREQ;
        end
      end
      ST_MEMREQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = line_addr(r_tag, r_index);
        if (mem_req_ready) begin
          w_state_nxt = ST_MEMWAIT;
        end else begin
          w_state_nxt = ST_MEMREQ;
        end
      end
      ST_MEMWAIT: begin
        if (mem_rsp_valid) begin
          w_state_nxt = ST_UPDATE;
        end else begin
          w_state_nxt = ST_MEMWAIT;
        end
      end
      ST_UPDATE: begin
        tag_addr    = r_index;
        tag_din     = {1'b1, r_tag};
        tag_we      = 1'b1;
        resp_valid  = 1'b1;
        resp_hit    = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

endmodule

// File: doc/tag_lookup_ctrl_t0.md
Name: tag_lookup_ctrl_t0

Overview:
Lookup and refill controller for cache way 0, sitting directly downstream of the way-0 tag RAM (3-bit index, 14-bit entry, synchronous read). It drives the tag RAM address, write data and write enable, and consumes its registered read data. For each CPU request it computes hit or miss, and on a miss fetches the line from memory and installs the new tag. After reset it sweeps the RAM so every valid bit is clear, because the RAM contents are file-initialised and not reset.

Parameters:
- AWIDTH, 3, index width; DEPTH = 1<<AWIDTH entries
- TWIDTH, 13, tag width; tag entry = {valid, tag} = TWIDTH+1 = 14 bits
- OWIDTH, 2, byte-offset width; request address width RA = TWIDTH+AWIDTH+OWIDTH = 18

Ports:
- clock, input, 1, sole clock, rising edge
- reset_n, input, 1, asynchronous active-low reset
- req_valid, input, 1, CPU request present
- req_ready, output, 1, controller accepts a request; high only in IDLE with flush low
- req_addr, input, RA, byte address: tag [RA-1:AWIDTH+OWIDTH], index [AWIDTH+OWIDTH-1:OWIDTH]
- flush, input, 1, pulse in IDLE re-runs the invalidate sweep
- resp_valid, output, 1, one-cycle response strobe
- resp_hit, output, 1, qualifies resp_valid: 1=hit, 0=miss serviced
- tag_addr, output, AWIDTH, tag RAM address
- tag_din, output, TWIDTH+1, tag RAM write data
- tag_we, output, 1, tag RAM write enable
- tag_dout, input, TWIDTH+1, tag RAM read data; valid the cycle after tag_addr is presented
- mem_req_valid, output, 1, line fetch request
- mem_req_ready, input, 1, memory accepts the fetch
- mem_req_addr, output, TWIDTH+AWIDTH, line address = {tag, index}
- mem_rsp_valid, input, 1, line data returned (data path lives outside this block)

Behaviour:
- States: INIT, IDLE, LOOKUP, MEMREQ, MEMWAIT, UPDATE.
- Reset (async assert): state=INIT, init counter=0. All outputs 0 except tag_we, which is 1 (INIT writes).
- INIT:
  - tag_addr=counter, tag_din=0, tag_we=1, counter increments each cycle.
  - After writing index DEPTH-1 → IDLE.
  - req_ready first rises DEPTH cycles after reset_n deasserts (8 by default).
- IDLE:
  - req_ready = !flush. tag_addr = req_addr index (combinational).
  - flush=1 → INIT (counter cleared); flush has priority over req_valid.
  - req_valid & req_ready → latch tag and index → LOOKUP.
- LOOKUP:
  - tag_addr = latched index.
  - hit = tag_dout[TWIDTH] & (tag_dout[TWIDTH-1:0] == latched tag).
  - Hit → resp_valid=1, resp_hit=1 → IDLE. Hit latency is 1 cycle after acceptance; throughput is one request per 2 cycles.
  - Miss → MEMREQ.
- MEMREQ: mem_req_valid=1, mem_req_addr={tag, index}, held stable until mem_req_ready; the handshake cycle → MEMWAIT.
- MEMWAIT: mem_req_valid=0; mem_rsp_valid → UPDATE. mem_rsp_valid is ignored in every other state.
- UPDATE: tag_addr=index, tag_din={1'b1, tag}, tag_we=1, resp_valid=1, resp_hit=0 → IDLE.
- Outputs are registered or decoded from the registered state; no combinational path from mem_* inputs to outputs.
- resp_valid is never high in two consecutive cycles.
- Reset mid-operation (any state) aborts immediately: mem_req_valid drops asynchronously, and the pending request is lost with no response.
- flush outside IDLE is ignored. The requester must hold flush until req_ready falls.

Decomposition:
- Package cache_t0_pkg: AWIDTH/TWIDTH/OWIDTH defaults, derived widths, state enum (3-bit), and field-extraction functions for tag, index and line address.
- No sub-module required. The init counter and FSM are inline, and the tag RAM is instantiated alongside this block by the parent.

Test Plan:
- Reset release → tag_we=1 for 8 cycles with tag_addr 0..7 and tag_din=0; req_ready rises on the 9th cycle.
- Cold miss, req_addr=0x14AD (tag 0x0A5, index 3):
  - mem_req_valid with mem_req_addr=0x52B, held through 3 cycles of mem_req_ready=0.
  - After mem_rsp_valid: tag_we with tag_addr=3, tag_din=0x20A5, resp_valid=1, resp_hit=0.
- Repeat req_addr=0x14AC → resp_valid=1, resp_hit=1 exactly 1 cycle after acceptance, and no mem_req_valid.
- Conflict, req_addr=0x34AD (tag 0x1A5, index 3) → miss, refill writes 0x21A5 at index 3. A subsequent 0x14AD misses.
- flush and req_valid asserted together in IDLE → req_ready=0, 8-cycle sweep. Afterwards 0x34AD misses.
- reset_n pulsed low while in MEMWAIT → mem_req_valid=0 at once, INIT sweep restarts, and no resp_valid is produced; a late mem_rsp_valid is ignored.
